clint_arb: RTL and testbench
============================

# clint_arb

Parametrised core-local interrupt controller and arbiter. It latches up to NUM_IRQ interrupt sources and arbitrates them by fixed priority. For the winning source it sequences the mepc/mstatus/mcause CSR writes, then redirects the pipeline to a direct or vectored handler address. It also handles the interrupt-return instruction. It sits between ID/EX (instruction, jump), the CSR file and ctrl (pipeline hold), and supersedes the single-timer-source interrupt block.

## Interface
Parameters:
- DATA_W, 16, data/CSR width
- ADDR_W, 16, address width
- NUM_IRQ, 4, number of sources (≥2); ID_W = $clog2(NUM_IRQ)
- VECTORED, 0, 0: handler = mtvec; 1: handler = mtvec + id*VEC_STRIDE
- VEC_STRIDE, 4, vector table entry spacing
- CAUSE_BASE, 16, mcause code of source 0
- MRET_INST, 16'h0000, encoding of interrupt-return instruction
- MIE_BIT, 3 / MPIE_BIT, 7, mstatus bit positions
- CSR_MEPC_A, CSR_MSTATUS_A, CSR_MCAUSE_A: CSR addresses, taken from the shared parameter header

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- irq_in  in  NUM_IRQ  raw interrupt requests
- irq_en  in  NUM_IRQ  per-source enable mask
- global_int_en  in  1  global enable (mstatus.MIE)
- inst_data  in  DATA_W  instruction in ID
- inst_addr  in  ADDR_W  address of instruction in ID
- jump_flag / jump_addr  in  1 / ADDR_W  taken jump from EX
- csr_mtvec, csr_mepc, csr_mstatus  in  DATA_W  current CSR values
- hold_flag_int  out  1  pipeline hold to ctrl
- csr_we  out  1  CSR write strobe
- csr_waddr  out  ADDR_W  CSR write address
- csr_wdata  out  DATA_W  CSR write data
- int_assert  out  1  one-cycle redirect strobe to EX
- int_addr  out  ADDR_W  redirect target
- int_id  out  ID_W  id of source being serviced

## Operation
- Edge capture: irq_d registers irq_in. pending[i] is set on the clock edge where irq_in[i] & ~irq_d[i]. It is cleared when source i is taken. Set and clear in the same cycle: set wins, so the source is taken again later.
- Take (combinational, state IDLE only): req = pending & irq_en. If global_int_en and req≠0, take fires; winner = lowest set index of req.
- On take, the block latches:
  - id = winner
  - ret_addr = jump_flag ? jump_addr : inst_addr
  - cause = (1<<(DATA_W-1)) | (CAUSE_BASE+id)
- Mret (IDLE, no take, inst_data==MRET_INST) fires mret. Take has priority over mret in the same cycle.
- Entry states, outputs decoded from registered state:
  - IDLE → MEPC: csr_we=1, waddr=CSR_MEPC_A, wdata=ret_addr
  - MEPC → MSTATUS: csr_we=1, wdata = csr_mstatus with MPIE←MIE and MIE←0
  - MSTATUS → MCAUSE: csr_we=1, wdata = cause
  - MCAUSE → ASSERT: int_assert=1, int_addr = csr_mtvec (VECTORED=0) or csr_mtvec + id*VEC_STRIDE, truncated to ADDR_W
  - ASSERT → IDLE
- Return states:
  - IDLE → RET_ST: csr_we=1, waddr=CSR_MSTATUS_A, wdata = csr_mstatus with MIE←MPIE and MPIE←1
  - RET_ST → RET_AS: int_assert=1, int_addr=csr_mepc
  - RET_AS → IDLE
- Illegal state encodings go to IDLE.
- In every state not listed above: csr_we=0, csr_waddr=0, csr_wdata=0, int_assert=0, int_addr=0.
- int_id holds the latched id from take until the next take.
- hold_flag_int = (state≠IDLE) | take | mret. It is forced to 0 while rst_n is low.
- No nesting: requests arriving during a sequence stay pending and are arbitrated in IDLE after completion, subject to global_int_en.

## Timing
- Reset values: state=IDLE, pending=0, irq_d=0, id=0, ret_addr=0, cause=0, and every output 0.
- Reset mid-sequence aborts immediately to IDLE. No partial CSR write is issued after rst_n rises.
- Entry latency:
  - Rising edge of irq_in sampled at edge k → pending at k.
  - Take in cycle k..k+1 → MEPC k+1, MSTATUS k+2, MCAUSE k+3, int_assert high for exactly one cycle, k+4..k+5.
  - hold is asserted from the take cycle through ASSERT inclusive.
- Mret latency: one CSR write cycle, then int_assert, then IDLE (3 cycles of hold including the detect cycle).
- Exactly one CSR write per cycle; csr_we is never high in the same cycle as int_assert.
- A source held high continuously produces one pending event only.

## Test plan
- irq_in=4'b0100, irq_en=all, global_int_en=1, inst_addr=0x0120, VECTORED=0, mtvec=0x0200, mstatus=0x0008 → writes in order: mepc=0x0120, then mstatus=0x0080, then mcause=0x8012; int_assert with int_addr=0x0200, int_id=2; hold lasts 5 cycles.
- irq_in 4'b1010 in the same cycle → source 1 serviced first (mcause 0x8011); source 3 serviced after return, once global_int_en=1 again.
- VECTORED=1, source 3, mtvec=0x0300 → int_addr=0x030C; jump_flag=1 with jump_addr=0x0444 → mepc=0x0444.
- irq_en[0]=0 with pending[0] set → no take; setting irq_en[0]=1 later → take fires. global_int_en=0 → no take.
- inst_data=0x0000 in IDLE, mstatus=0x0080, mepc=0x0122 → mstatus write 0x0088, then int_assert with int_addr=0x0122.
- rst_n low during MSTATUS → all outputs 0 immediately; pending cleared; no further csr_we after release.

Source files
------------

// File: rtl/clint_arb.sv
// Core-local interrupt controller: edge-captured sources, fixed-priority arbitration,
// mepc/mstatus/mcause entry sequence, handler redirect and mret handling.
module clint_arb #(
  parameter int                DATA_W        = 16,
  parameter int                ADDR_W        = 16,
  parameter int                NUM_IRQ       = 4,
  parameter int                VECTORED      = 0,
  parameter int                VEC_STRIDE    = 4,
  parameter int                CAUSE_BASE    = 16,
  parameter logic [DATA_W-1:0] MRET_INST     = '0,
  parameter int                MIE_BIT       = 3,
  parameter int                MPIE_BIT      = 7,
  parameter logic [ADDR_W-1:0] CSR_MEPC_A    = ADDR_W'('h341),
  parameter logic [ADDR_W-1:0] CSR_MSTATUS_A = ADDR_W'('h300),
  parameter logic [ADDR_W-1:0] CSR_MCAUSE_A  = ADDR_W'('h342)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IRQ-1:0]         irq_in_i,
  input  logic [NUM_IRQ-1:0]         irq_en_i,
  input  logic                       global_int_en_i,
  input  logic [DATA_W-1:0]          inst_data_i,
  input  logic [ADDR_W-1:0]          inst_addr_i,
  input  logic                       jump_flag_i,
  input  logic [ADDR_W-1:0]          jump_addr_i,
  input  logic [DATA_W-1:0]          csr_mtvec_i,
  input  logic [DATA_W-1:0]          csr_mepc_i,
  input  logic [DATA_W-1:0]          csr_mstatus_i,
  output logic                       hold_flag_int_o,
  output logic                       csr_we_o,
  output logic [ADDR_W-1:0]          csr_waddr_o,
  output logic [DATA_W-1:0]          csr_wdata_o,
  output logic                       int_assert_o,
  output logic [ADDR_W-1:0]          int_addr_o,
  output logic [$clog2(NUM_IRQ)-1:0] int_id_o
);

  localparam int ID_W = $clog2(NUM_IRQ);

  // IDLE: arbitrate | MEPC/MSTATUS/MCAUSE: entry CSR writes | ASSERT: redirect to handler
  // RET_ST: mret mstatus restore | RET_AS: redirect to mepc
  typedef enum logic [2:0] {
    S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_ASSERT, S_RET_ST, S_RET_AS
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  irq_d_q, irq_d_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   ret_addr_q, ret_addr_d;
  logic [DATA_W-1:0]   cause_q, cause_d;

  logic [NUM_IRQ-1:0]  req, clr;
  logic [ID_W-1:0]     winner;
  logic                take, mret;
  logic [DATA_W-1:0]   mst_entry, mst_ret, vec_tgt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      irq_d_q    <= '0;
      id_q       <= '0;
      ret_addr_q <= '0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_d_q    <= irq_d_d;
      id_q       <= id_d;
      ret_addr_q <= ret_addr_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    ret_addr_d   = ret_addr_q;
    cause_d      = cause_q;
    irq_d_d      = irq_in_i;
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_wdata_o  = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;

    req    = pending_q & irq_en_i;
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) winner = ID_W'(i);
    end
    take = (state_q == S_IDLE) && global_int_en_i && (|req);
    mret = (state_q == S_IDLE) && !take && (inst_data_i == MRET_INST);

    // A new edge on the source being taken survives the clear, so it is serviced again.
    clr       = take ? (NUM_IRQ'(1) << winner) : '0;
    pending_d = (pending_q & ~clr) | (irq_in_i & ~irq_d_q);

    mst_entry           = csr_mstatus_i;
    mst_entry[MPIE_BIT] = csr_mstatus_i[MIE_BIT];
    mst_entry[MIE_BIT]  = 1'b0;
    mst_ret             = csr_mstatus_i;
    mst_ret[MIE_BIT]    = csr_mstatus_i[MPIE_BIT];
    mst_ret[MPIE_BIT]   = 1'b1;

    vec_tgt = (VECTORED != 0) ? csr_mtvec_i + DATA_W'(VEC_STRIDE) * DATA_W'(id_q)
                              : csr_mtvec_i;

    case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d    = S_MEPC;
          id_d       = winner;
          ret_addr_d = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_d    = (DATA_W'(1) << (DATA_W - 1)) | (DATA_W'(CAUSE_BASE) + DATA_W'(winner));
        end else if (mret) begin
          state_d = S_RET_ST;
        end
      end
      S_MEPC: begin
        state_d     = S_MSTATUS;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC_A;
        csr_wdata_o = DATA_W'(ret_addr_q);
      end
      S_MSTATUS: begin
        state_d     = S_MCAUSE;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS_A;
        csr_wdata_o = mst_entry;
      end
      S_MCAUSE: begin
        state_d     = S_ASSERT;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE_A;
        csr_wdata_o = cause_q;
      end
      S_ASSERT: begin
        state_d      = S_IDLE;
        int_assert_o = 1'b1;
        int_addr_o   = ADDR_W'(vec_tgt);
      end
      S_RET_ST: begin
        state_d     = S_RET_AS;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS_A;
        csr_wdata_o = mst_ret;
      end
      S_RET_AS: begin
        state_d      = S_IDLE;
        int_assert_o = 1'b1;
        int_addr_o   = ADDR_W'(csr_mepc_i);
      end
      default: state_d = S_IDLE;
    endcase

    hold_flag_int_o = rst_n & ((state_q != S_IDLE) | take | mret);
  end

  assign int_id_o = id_q;

endmodule

// File: tb/tb_clint_arb.sv
// Scoreboard bench for clint_arb: expected CSR writes / redirects are queued with the
// stimulus and matched against a direct-mode and a vectored-mode instance.
module tb_clint_arb;

  localparam logic [15:0] MEPC_A = 16'h0341;
  localparam logic [15:0] MST_A  = 16'h0300;
  localparam logic [15:0] MCA_A  = 16'h0342;
  localparam logic [15:0] NOP    = 16'h0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  irq_in, irq_en;
  logic        gie, jump_flag;
  logic [15:0] inst_data, inst_addr, jump_addr, mtvec, mepc, mstatus;

  logic        d_hold, d_we, d_as;
  logic [15:0] d_waddr, d_wdata, d_addr;
  logic [1:0]  d_id;
  logic        v_hold, v_we, v_as;
  logic [15:0] v_waddr, v_wdata, v_addr;
  logic [1:0]  v_id;

  always #5 clk = ~clk;

  clint_arb #(.VECTORED(0), .CSR_MEPC_A(MEPC_A), .CSR_MSTATUS_A(MST_A), .CSR_MCAUSE_A(MCA_A)) u_dir (
    .clk(clk), .rst_n(rst_n), .irq_in_i(irq_in), .irq_en_i(irq_en), .global_int_en_i(gie),
    .inst_data_i(inst_data), .inst_addr_i(inst_addr), .jump_flag_i(jump_flag),
    .jump_addr_i(jump_addr), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mstatus),
    .hold_flag_int_o(d_hold), .csr_we_o(d_we), .csr_waddr_o(d_waddr), .csr_wdata_o(d_wdata),
    .int_assert_o(d_as), .int_addr_o(d_addr), .int_id_o(d_id));

  clint_arb #(.VECTORED(1), .CSR_MEPC_A(MEPC_A), .CSR_MSTATUS_A(MST_A), .CSR_MCAUSE_A(MCA_A)) u_vec (
    .clk(clk), .rst_n(rst_n), .irq_in_i(irq_in), .irq_en_i(irq_en), .global_int_en_i(gie),
    .inst_data_i(inst_data), .inst_addr_i(inst_addr), .jump_flag_i(jump_flag),
    .jump_addr_i(jump_addr), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mstatus),
    .hold_flag_int_o(v_hold), .csr_we_o(v_we), .csr_waddr_o(v_waddr), .csr_wdata_o(v_wdata),
    .int_assert_o(v_as), .int_addr_o(v_addr), .int_id_o(v_id));

  typedef struct packed {
    logic        is_as;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  ev_t exp_q[$];
  ev_t got_ev, exp_ev;
  int  errors = 0;
  int  checks = 0;

  // Scoreboard: every write or redirect from the direct instance must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ({v_hold, v_we, v_waddr, v_wdata, v_as, v_id} !== {d_hold, d_we, d_waddr, d_wdata, d_as, d_id}) begin
        errors++;
        $display("FAIL vec_vs_dir: vec we=%b wa=%h wd=%h as=%b id=%0d, required dir we=%b wa=%h wd=%h as=%b id=%0d",
                 v_we, v_waddr, v_wdata, v_as, v_id, d_we, d_waddr, d_wdata, d_as, d_id);
      end
      if (d_we || d_as) begin
        checks++;
        if (d_we && d_as) begin
          errors++;
          $display("FAIL we_with_assert: we=%b assert=%b, required not both", d_we, d_as);
        end
        got_ev = d_as ? '{1'b1, d_addr, 16'(d_id)} : '{1'b0, d_waddr, d_wdata};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got is_as=%b a=%h d=%h, required none", got_ev.is_as, got_ev.a, got_ev.d);
        end else begin
          exp_ev = exp_q.pop_front();
          if (got_ev !== exp_ev) begin
            errors++;
            $display("FAIL event: got is_as=%b a=%h d=%h, required is_as=%b a=%h d=%h",
                     got_ev.is_as, got_ev.a, got_ev.d, exp_ev.is_as, exp_ev.a, exp_ev.d);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_take(input logic [15:0] ret, input logic [15:0] mst_out,
                           input logic [15:0] cause, input logic [15:0] tgt, input logic [1:0] id);
    exp_q.push_back('{1'b0, MEPC_A, ret});
    exp_q.push_back('{1'b0, MST_A, mst_out});
    exp_q.push_back('{1'b0, MCA_A, cause});
    exp_q.push_back('{1'b1, tgt, 16'(id)});
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (exp_q.size() == 0 && !d_hold) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: queue=%0d hold=%b, required empty and idle", name, exp_q.size(), d_hold);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq_in = '0; irq_en = 4'hf; gie = 1'b1; jump_flag = 1'b0; jump_addr = '0;
    inst_data = 16'h0000; inst_addr = 16'h0100; mtvec = 16'h0200; mepc = '0; mstatus = 16'h0008;
    step(); step();
    checks++;
    if ({d_hold, d_we, d_as, d_waddr, d_wdata, d_addr, d_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: hold=%b we=%b as=%b wa=%h wd=%h ia=%h id=%0d, required all 0",
               d_hold, d_we, d_as, d_waddr, d_wdata, d_addr, d_id);
    end
    inst_data = NOP;
    rst_n = 1'b1;
    step(); step();
    checks++;
    if ({d_hold, d_we, d_as, d_waddr, d_wdata, d_addr, d_id} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: hold=%b we=%b as=%b id=%0d, required all 0", d_hold, d_we, d_as, d_id);
    end
  endtask

  task automatic test_single();
    int cnt = 0, first = -1, last = -1;
    inst_addr = 16'h0120; mtvec = 16'h0200; mstatus = 16'h0008;
    push_take(16'h0120, 16'h0080, 16'h8012, 16'h0200, 2'd2);
    irq_in = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      step();
      if (d_hold) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    checks++;
    if (cnt != 5 || first != 0 || last != 4) begin
      errors++;
      $display("FAIL single_hold: cycles=%0d first=%0d last=%0d, required 5 0 4", cnt, first, last);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain: left=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (d_id !== 2'd2) begin
      errors++;
      $display("FAIL single_id: got %0d, required 2", d_id);
    end
    irq_in = '0;
    step();
  endtask

  task automatic test_two_sources();
    inst_addr = 16'h0130;
    push_take(16'h0130, 16'h0080, 16'h8011, 16'h0200, 2'd1);
    irq_in = 4'b1010;
    step(); step();
    gie = 1'b0;
    wait_idle("src1", 20);
    checks++;
    if (d_id !== 2'd1) begin
      errors++;
      $display("FAIL two_first_id: got %0d, required 1", d_id);
    end
    inst_data = 16'h0000; mstatus = 16'h0080; mepc = 16'h0130;
    exp_q.push_back('{1'b0, MST_A, 16'h0088});
    exp_q.push_back('{1'b1, 16'h0130, 16'd1});
    step();
    inst_data = NOP; gie = 1'b1; mstatus = 16'h0008;
    push_take(16'h0130, 16'h0080, 16'h8013, 16'h0200, 2'd3);
    wait_idle("src3", 20);
    checks++;
    if (d_id !== 2'd3) begin
      errors++;
      $display("FAIL two_second_id: got %0d, required 3", d_id);
    end
    irq_in = '0;
    step();
  endtask

  task automatic test_vectored();
    bit          seen = 1'b0;
    logic [15:0] vaddr = '0;
    mtvec = 16'h0300; jump_flag = 1'b1; jump_addr = 16'h0444; inst_addr = 16'h0150;
    push_take(16'h0444, 16'h0080, 16'h8013, 16'h0300, 2'd3);
    irq_in = 4'b1000;
    for (int i = 0; i < 12; i++) begin
      step();
      if (v_as && !seen) begin
        seen  = 1'b1;
        vaddr = v_addr;
      end
    end
    checks++;
    if (!seen || vaddr !== 16'h030C) begin
      errors++;
      $display("FAIL vectored_addr: seen=%b addr=%h, required 1 030c", seen, vaddr);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL vectored_drain: left=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
    jump_flag = 1'b0; mtvec = 16'h0200; irq_in = '0;
    step();
  endtask

  task automatic test_mask();
    int cnt = 0;
    inst_addr = 16'h0160;
    irq_en = 4'b1110;
    irq_in = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      if (d_hold || d_we) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL masked_take: busy cycles=%0d, required 0", cnt);
    end
    irq_en = 4'hf;
    push_take(16'h0160, 16'h0080, 16'h8010, 16'h0200, 2'd0);
    wait_idle("unmask", 20);
    gie = 1'b0;
    irq_in = 4'b0011;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (d_hold || d_we) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL gie_off_take: busy cycles=%0d, required 0", cnt);
    end
    gie = 1'b1;
    push_take(16'h0160, 16'h0080, 16'h8011, 16'h0200, 2'd1);
    wait_idle("gie_on", 20);
    irq_in = '0;
    step();
  endtask

  task automatic test_mret();
    int cnt = 0;
    mstatus = 16'h0080; mepc = 16'h0122;
    exp_q.push_back('{1'b0, MST_A, 16'h0088});
    exp_q.push_back('{1'b1, 16'h0122, 16'd1});
    inst_data = 16'h0000;
    #1;
    checks++;
    if (d_hold !== 1'b1) begin
      errors++;
      $display("FAIL mret_detect_hold: got %b, required 1", d_hold);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) inst_data = NOP;
      if (d_hold) cnt++;
    end
    checks++;
    if (cnt != 2) begin
      errors++;
      $display("FAIL mret_hold: cycles after detect=%0d, required 2", cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mret_drain: left=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
    mstatus = 16'h0008;
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    inst_addr = 16'h0170;
    exp_q.push_back('{1'b0, MEPC_A, 16'h0170});
    exp_q.push_back('{1'b0, MST_A, 16'h0080});
    irq_in = 4'b0100;
    step(); step(); step();
    rst_n = 1'b0;
    irq_in = '0;
    #1;
    checks++;
    if ({d_hold, d_we, d_as, d_waddr, d_wdata, d_addr, d_id} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: hold=%b we=%b as=%b wa=%h wd=%h id=%0d, required all 0",
               d_hold, d_we, d_as, d_waddr, d_wdata, d_id);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_partial: writes missing=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (d_we || d_hold || d_as) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++;
      $display("FAIL midreset_release: busy cycles=%0d, required 0", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_sources();
    test_vectored();
    test_mask();
    test_mret();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
